dram_read_arbiter: RTL

//  Parametrised successor to the fixed-rotation DRAM read requester.
//  - Collects read-address requests from CHANNELS instrument voices.
//  - Picks one per cycle with a work-conserving round-robin that skips idle channels.
//  - Packs the pick with the chunk-held sample period into one word.
//  - Drives that word to the DRAM-side clock-domain FIFO. Unlike its predecessor, it honours FIFO backpressure.

---
 rtl/dram_read_arbiter_pkg.sv | 28 ++
 rtl/dram_read_arbiter_if.sv | 47 ++++
 rtl/dram_read_arbiter_rr_arbiter.sv | 60 ++++++
 rtl/dram_read_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dram_read_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dram_req_pkg
// Shared types and helpers for the DRAM read arbiter.
//   dram_req_t    : packed layout of one outgoing word {pad, period, addr}
//                   at the default widths (24-bit addr, 14-bit period, 40-bit word)
//   clamp_period  : maps a requested sample period of 0 onto 1 so the chunk
//                   timer always has a non-zero terminal count
// -----------------------------------------------------------------------------
package dram_req_pkg;

    localparam int DEF_ADDR_W   = 24;
    localparam int DEF_PERIOD_W = 14;
    localparam int DEF_OUT_W    = 40;
    localparam int DEF_PAD_W    = DEF_OUT_W - DEF_PERIOD_W - DEF_ADDR_W;

    typedef struct packed {
        logic [DEF_PAD_W-1:0]    pad;
        logic [DEF_PERIOD_W-1:0] period;
        logic [DEF_ADDR_W-1:0]   addr;
    } dram_req_t;

    // A zero period would make the chunk terminal underflow, so it is
    // treated as the shortest legal period instead.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/dram_read_arbiter_if.sv
// -----------------------------------------------------------------------------
// dram_read_arbiter_if
// Bundles the voice request bus, the sample-period input and the FIFO-side
// stream of the DRAM read arbiter.
//   req_addr/req_valid/req_ready : per-channel request handshake
//   sample_period                : live sample period, latched at chunk bounds
//   out_tvalid/out_tready/out_tdata/out_tchan : stream towards the DRAM FIFO
//   sample_counter/chunk_start   : chunk timer position and wrap pulse
//   stall_count                  : saturating backpressure counter
// Modports:
//   master : the voices / FIFO side (drives requests and out_tready)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface dram_read_arbiter_if #(
    parameter int CHANNELS   = 8,
    parameter int ADDR_W     = 24,
    parameter int PERIOD_W   = 14,
    parameter int OUT_W      = 40,
    parameter int CHUNK_LOG2 = 3
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0][ADDR_W-1:0]   req_addr;
    logic [CHANNELS-1:0]               req_valid;
    logic [CHANNELS-1:0]               req_ready;
    logic [PERIOD_W-1:0]               sample_period;
    logic                              out_tvalid;
    logic                              out_tready;
    logic [OUT_W-1:0]                  out_tdata;
    logic [CHAN_W-1:0]                 out_tchan;
    logic [PERIOD_W+CHUNK_LOG2-1:0]    sample_counter;
    logic                              chunk_start;
    logic [15:0]                       stall_count;

    modport master (
        output req_addr, req_valid, sample_period, out_tready,
        input  req_ready, out_tvalid, out_tdata, out_tchan,
               sample_counter, chunk_start, stall_count
    );

    modport slave (
        input  req_addr, req_valid, sample_period, out_tready,
        output req_ready, out_tvalid, out_tdata, out_tchan,
               sample_counter, chunk_start, stall_count
    );

endinterface

// File: rtl/dram_read_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational work-conserving round-robin picker.
//   req     : request vector
//   en      : grant enable (gnt is all zero when low)
//   ptr     : highest-priority index for this cycle
//   gnt     : one-hot grant
//   gnt_idx : index of the picked request (valid when any is high)
//   any     : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 8,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [IDX_W:0] pos;
    logic           hit;

    // The lower half holds only requests at or above ptr, the upper half holds
    // every request, so the lowest set bit of the doubled vector is the first
    // requester in circular order starting at ptr.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};

        pos = '0;
        hit = 1'b0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i]) begin
                pos = (IDX_W+1)'(i);
                hit = 1'b1;
            end
        end

        if (pos >= (IDX_W+1)'(N)) begin
            gnt_idx = IDX_W'(pos - (IDX_W+1)'(N));
        end else begin
            gnt_idx = IDX_W'(pos);
        end

        any = hit;
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = en && hit && (gnt_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dram_read_arbiter.sv
// -----------------------------------------------------------------------------
// dram_read_arbiter
// Collects read-address requests from CHANNELS voices, grants one per cycle
// round-robin, packs it with the chunk-held sample period and pushes it into a
// one-slot output register that honours FIFO backpressure.
//   clk, rst : system clock, async active-high reset
//   bus      : dram_read_arbiter_if.slave (requests, period, output stream,
//              chunk timer and stall counter)
// -----------------------------------------------------------------------------
module dram_read_arbiter
    import dram_req_pkg::*;
#(
    parameter int CHANNELS     = 8,
    parameter int ADDR_W       = 24,
    parameter int PERIOD_W     = 14,
    parameter int OUT_W        = 40,
    parameter int CHUNK_LOG2   = 3,
    parameter int PERIOD_RESET = 2272
) (
    input  logic                 clk,
    input  logic                 rst,
    dram_read_arbiter_if.slave   bus
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W  = PERIOD_W + CHUNK_LOG2;

    logic [CHAN_W-1:0]   ptr_q, ptr_d;
    logic                out_tvalid_q, out_tvalid_d;
    logic [OUT_W-1:0]    out_tdata_q, out_tdata_d;
    logic [CHAN_W-1:0]   out_tchan_q, out_tchan_d;
    logic [PERIOD_W-1:0] period_hold_q, period_hold_d;
    logic [CNT_W-1:0]    sample_counter_q, sample_counter_d;
    logic                chunk_start_q, chunk_start_d;
    logic [15:0]         stall_count_q, stall_count_d;

    logic                accepting;
    logic                grantEn;
    logic                grant;
    logic                anyReq;
    logic [CHANNELS-1:0] gnt;
    logic [CHAN_W-1:0]   gntIdx;
    logic [CNT_W-1:0]    terminal;

    // The output slot can take a new word when it is empty or being drained
    // this very cycle; reset also masks the combinational grant.
    assign accepting = !out_tvalid_q || bus.out_tready;
    assign grantEn   = accepting && !rst;
    assign grant     = grantEn && anyReq;

    rr_arbiter #(
        .N (CHANNELS)
    ) u_rr (
        .req     (bus.req_valid),
        .en      (grantEn),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gntIdx),
        .any     (anyReq)
    );

    assign terminal = (CNT_W'(period_hold_q) << CHUNK_LOG2) - CNT_W'(1);

    // Next-state logic: pointer, output slot, chunk timer and stall counter.
    always_comb begin
        ptr_d            = ptr_q;
        out_tvalid_d     = out_tvalid_q;
        out_tdata_d      = out_tdata_q;
        out_tchan_d      = out_tchan_q;
        period_hold_d    = period_hold_q;
        sample_counter_d = sample_counter_q;
        chunk_start_d    = 1'b0;
        stall_count_d    = stall_count_q;

        // A grant on a draining cycle is a pop and a push at once.
        if (grant) begin
            ptr_d        = (gntIdx == CHAN_W'(CHANNELS - 1)) ? '0 : gntIdx + CHAN_W'(1);
            out_tvalid_d = 1'b1;
            out_tdata_d  = OUT_W'({period_hold_q, bus.req_addr[gntIdx]});
            out_tchan_d  = gntIdx;
        end else if (bus.out_tready) begin
            out_tvalid_d = 1'b0;
        end

        // The period is only resampled at a chunk boundary; a grant on the
        // terminal cycle still packs the old value above.
        if (sample_counter_q == terminal) begin
            sample_counter_d = '0;
            chunk_start_d    = 1'b1;
            period_hold_d    = PERIOD_W'(clamp_period(32'(bus.sample_period)));
        end else begin
            sample_counter_d = sample_counter_q + CNT_W'(1);
        end

        if (out_tvalid_q && !bus.out_tready && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State registers; reset discards any held word and restores the
    // power-on period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q            <= '0;
            out_tvalid_q     <= 1'b0;
            out_tdata_q      <= '0;
            out_tchan_q      <= '0;
            period_hold_q    <= PERIOD_W'(PERIOD_RESET);
            sample_counter_q <= '0;
            chunk_start_q    <= 1'b0;
            stall_count_q    <= '0;
        end else begin
            ptr_q            <= ptr_d;
            out_tvalid_q     <= out_tvalid_d;
            out_tdata_q      <= out_tdata_d;
            out_tchan_q      <= out_tchan_d;
            period_hold_q    <= period_hold_d;
            sample_counter_q <= sample_counter_d;
            chunk_start_q    <= chunk_start_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign bus.req_ready      = gnt;
    assign bus.out_tvalid     = out_tvalid_q;
    assign bus.out_tdata      = out_tdata_q;
    assign bus.out_tchan      = out_tchan_q;
    assign bus.sample_counter = sample_counter_q;
    assign bus.chunk_start    = chunk_start_q;
    assign bus.stall_count    = stall_count_q;

endmodule
